// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM/DBG requesters, the memory port arbiter
// and the single-port 1024 x 32 RAM of the MIPS32 pipeline.
interface mem_port_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int CW = 16
);
   logic          halted;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;

   logic [DW-1:0] rdata;

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   logic [CW-1:0] conflict_cnt;

   modport slave (
      input  halted,
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  ram_rdata,
      output if_gnt, if_rvalid,
      output mem_gnt, mem_rvalid,
      output dbg_gnt, dbg_rvalid,
      output rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      output conflict_cnt
   );

   modport master (
      output halted,
      output if_req, if_addr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output ram_rdata,
      input  if_gnt, if_rvalid,
      input  mem_gnt, mem_rvalid,
      input  dbg_gnt, dbg_rvalid,
      input  rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      input  conflict_cnt
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the shared single-port instruction/data memory:
// MEM > IF > DBG with starvation promotion, halt gating and a conflict counter.
module mem_port_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CW           = 16
) (
   input  logic              clk1,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0]    LP_LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [CW-1:0] LP_CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] LP_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   // Vector bit order everywhere: [0] = MEM, [1] = IF, [2] = DBG (base priority order).
   function automatic logic [2:0] pick_first(input logic [2:0] v);
      logic [2:0] r;
      if (v[0]) begin
         r = 3'b001;
      end else if (v[1]) begin
         r = 3'b010;
      end else if (v[2]) begin
         r = 3'b100;
      end else begin
         r = 3'b000;
      end
      return r;
   endfunction

   function automatic logic two_or_more(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   function automatic logic [3:0] wait_next(input logic [3:0] cur, input logic elig,
                                            input logic gnt);
      logic [3:0] n;
      if (!elig || gnt) begin
         n = 4'd0;
      end else if (cur >= LP_LIMIT) begin
         n = LP_LIMIT;
      end else begin
         n = cur + 4'd1;
      end
      return n;
   endfunction

   logic [2:0]    w_elig;
   logic [2:0]    w_starved;
   logic [2:0]    w_gnt;
   logic [2:0]    w_rd_gnt;
   logic          w_conflict;
   logic          w_ram_we;
   logic [AW-1:0] w_ram_addr;
   logic [DW-1:0] w_ram_wdata;

   logic [3:0]    r_wait_mem;
   logic [3:0]    r_wait_if;
   logic [3:0]    r_wait_dbg;
   logic [2:0]    r_rd_owner;
   logic [CW-1:0] r_conflict_cnt;

   // Eligibility, starvation detection and the single-winner grant.
   always_comb begin
      w_elig    = {bus.dbg_req, bus.if_req & ~bus.halted, bus.mem_req};
      w_starved = w_elig & {r_wait_dbg == LP_LIMIT, r_wait_if == LP_LIMIT,
                            r_wait_mem == LP_LIMIT};
      if (!rst_n) begin
         w_gnt = 3'b000;
      end else if (|w_starved) begin
         w_gnt = pick_first(w_starved);
      end else begin
         w_gnt = pick_first(w_elig);
      end
      w_conflict = two_or_more(w_elig);
      w_rd_gnt   = w_gnt & {~bus.dbg_we, 1'b1, ~bus.mem_we};
   end

   // RAM command mux: winner's access goes out in the grant cycle.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = {AW{1'b0}};
      w_ram_wdata = {DW{1'b0}};
      case (w_gnt)
         3'b001: begin
            w_ram_we    = bus.mem_we;
            w_ram_addr  = bus.mem_addr;
            w_ram_wdata = bus.mem_wdata;
         end
         3'b010: begin
            w_ram_addr  = bus.if_addr;
         end
         3'b100: begin
            w_ram_we    = bus.dbg_we;
            w_ram_addr  = bus.dbg_addr;
            w_ram_wdata = bus.dbg_wdata;
         end
         default: begin
            w_ram_we    = 1'b0;
            w_ram_addr  = {AW{1'b0}};
            w_ram_wdata = {DW{1'b0}};
         end
      endcase
   end

   // Per-port wait counters; IF drops to 0 while halted since it is then ineligible.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_mem <= 4'd0;
         r_wait_if  <= 4'd0;
         r_wait_dbg <= 4'd0;
      end else begin
         r_wait_mem <= wait_next(r_wait_mem, w_elig[0], w_gnt[0]);
         r_wait_if  <= wait_next(r_wait_if,  w_elig[1], w_gnt[1]);
         r_wait_dbg <= wait_next(r_wait_dbg, w_elig[2], w_gnt[2]);
      end
   end

   // Owner of the read whose data returns next cycle; reset drops it.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_owner <= 3'b000;
      end else begin
         r_rd_owner <= w_rd_gnt;
      end
   end

   // Saturating count of cycles with two or more eligible requesters.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= {CW{1'b0}};
      end else if (w_conflict && (r_conflict_cnt != LP_CNT_MAX)) begin
         r_conflict_cnt <= r_conflict_cnt + LP_CNT_ONE;
      end else begin
         r_conflict_cnt <= r_conflict_cnt;
      end
   end

   assign bus.mem_gnt      = w_gnt[0];
   assign bus.if_gnt       = w_gnt[1];
   assign bus.dbg_gnt      = w_gnt[2];
   assign bus.mem_rvalid   = r_rd_owner[0];
   assign bus.if_rvalid    = r_rd_owner[1];
   assign bus.dbg_rvalid   = r_rd_owner[2];
   assign bus.rdata        = (|r_rd_owner) ? bus.ram_rdata : {DW{1'b0}};
   assign bus.ram_en       = |w_gnt;
   assign bus.ram_we       = w_ram_we;
   assign bus.ram_addr     = w_ram_addr;
   assign bus.ram_wdata    = w_ram_wdata;
   assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a cycle-level
// reference model of the arbitration rules plus a behavioural RAM.
module tb_mem_port_arbiter;
   localparam int AW      = 10;
   localparam int DW      = 32;
   localparam int CW      = 16;
   localparam int LIM     = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk1;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   mem_port_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .CW(CW)) dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   // Behavioural single-port RAM, filled once on the first clock edge.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   bit            ram_ready = 1'b0;
   always @(posedge clk1) begin
      if (!ram_ready) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= ram[bus.ram_addr];
      end
   end

   // Requester drive state, index 0 = MEM, 1 = IF, 2 = DBG.
   logic          req   [3];
   logic          we    [3];
   logic [AW-1:0] addr  [3];
   logic [DW-1:0] wdata [3];
   logic          halted_v;

   // Reference model state.
   int            wait_c [3];
   int            exp_conf;
   int            rd_own;
   logic [DW-1:0] rd_val;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            last_win;
   logic [2:0]    obs_gnt;
   logic [2:0]    obs_rv;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.halted    = halted_v;
      bus.mem_req   = req[0];
      bus.mem_we    = we[0];
      bus.mem_addr  = addr[0];
      bus.mem_wdata = wdata[0];
      bus.if_req    = req[1];
      bus.if_addr   = addr[1];
      bus.dbg_req   = req[2];
      bus.dbg_we    = we[2];
      bus.dbg_addr  = addr[2];
      bus.dbg_wdata = wdata[2];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) wait_c[i] = 0;
      exp_conf = 0;
      rd_own   = -1;
      rd_val   = '0;
      last_win = -1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      end
      halted_v = 1'b0;
      drive();
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk1);
      model_reset();
      @(negedge clk1);
      rst_n = 1'b1;
      @(posedge clk1);
      #1;
   endtask

   // One cycle: apply inputs, compare at negedge against the model, advance the model.
   task automatic step();
      logic [2:0] el;
      logic [2:0] eg;
      logic [2:0] erv;
      int         win;
      int         nel;
      drive();
      @(negedge clk1);
      el[0] = req[0];
      el[1] = req[1] && !halted_v;
      el[2] = req[2];
      win = -1;
      for (int i = 0; i < 3; i++) if (win < 0 && el[i] && wait_c[i] >= LIM) win = i;
      for (int i = 0; i < 3; i++) if (win < 0 && el[i]) win = i;
      eg = 3'b000;
      if (win >= 0) eg[win] = 1'b1;
      erv = 3'b000;
      if (rd_own >= 0) erv[rd_own] = 1'b1;
      obs_gnt = {bus.dbg_gnt, bus.if_gnt, bus.mem_gnt};
      obs_rv  = {bus.dbg_rvalid, bus.if_rvalid, bus.mem_rvalid};
      check("gnt", 64'(obs_gnt), 64'(eg));
      check("ram_en", 64'(bus.ram_en), 64'(win >= 0));
      if (win >= 0) begin
         check("ram_we", 64'(bus.ram_we), 64'(we[win] && win != 1));
         check("ram_addr", 64'(bus.ram_addr), 64'(addr[win]));
         if (we[win] && win != 1) check("ram_wdata", 64'(bus.ram_wdata), 64'(wdata[win]));
      end else begin
         check("ram_we_idle", 64'(bus.ram_we), 64'd0);
      end
      check("rvalid", 64'(obs_rv), 64'(erv));
      check("rdata", 64'(bus.rdata), (rd_own >= 0) ? 64'(rd_val) : 64'd0);
      check("conflict_cnt", 64'(bus.conflict_cnt), 64'(exp_conf));
      nel = int'(el[0]) + int'(el[1]) + int'(el[2]);
      if (nel >= 2 && exp_conf < CNT_MAX) exp_conf++;
      for (int i = 0; i < 3; i++) begin
         if (el[i] && i != win) wait_c[i]++;
         else                   wait_c[i] = 0;
      end
      rd_own = -1;
      if (win >= 0) begin
         if (we[win] && win != 1) ref_mem[addr[win]] = wdata[win];
         else begin
            rd_own = win;
            rd_val = ref_mem[addr[win]];
         end
      end
      last_win = win;
      @(posedge clk1);
      #1;
   endtask

   // Granted or idle ports pick a fresh random request; waiting ports hold theirs.
   task automatic refresh(input int pct, input bit force_on);
      for (int p = 0; p < 3; p++) begin
         if (last_win == p || !req[p]) begin
            req[p]   = (force_on && p != 1) ? 1'b1 : ($urandom_range(0, 99) < pct);
            we[p]    = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            addr[p]  = AW'($urandom_range(0, (1 << AW) - 1));
            wdata[p] = $urandom;
         end
      end
      if (!force_on && $urandom_range(0, 19) == 0) halted_v = !halted_v;
   endtask

   logic [2:0] g_tab [4];
   logic [2:0] r_tab [4];
   int         mcount;

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      reset_dut();

      // Reset during an in-flight read.
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h005;
      drive();
      @(negedge clk1);
      check("t1_mem_gnt", 64'(bus.mem_gnt), 64'd1);
      rst_n = 1'b0;
      #1;
      idle_inputs();
      #1;
      check("t1_rst_gnt", 64'({bus.dbg_gnt, bus.if_gnt, bus.mem_gnt}), 64'd0);
      check("t1_rst_rvalid", 64'({bus.dbg_rvalid, bus.if_rvalid, bus.mem_rvalid}), 64'd0);
      check("t1_rst_ram", 64'({bus.ram_en, bus.ram_we, bus.ram_addr}), 64'd0);
      check("t1_rst_wdata", 64'(bus.ram_wdata), 64'd0);
      check("t1_rst_rdata", 64'(bus.rdata), 64'd0);
      check("t1_rst_conf", 64'(bus.conflict_cnt), 64'd0);
      model_reset();
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      rst_n = 1'b1;
      @(posedge clk1);
      #1;
      repeat (3) begin
         step();
         check("t1_no_rvalid", 64'(obs_rv[0]), 64'd0);
      end

      // Single read latency after a debug preload.
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'h010; wdata[2] = 32'hDEAD_BEEF;
      step();
      req[2] = 1'b0;
      req[1] = 1'b1; addr[1] = 10'h010;
      step();
      check("t2_if_gnt", 64'(obs_gnt), 64'd2);
      req[1] = 1'b0;
      drive();
      check("t2_if_rvalid", 64'(bus.if_rvalid), 64'd1);
      check("t2_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
      step();

      // Starvation promotion of IF under continuous MEM traffic.
      reset_dut();
      mcount = 0;
      req[0] = 1'b1; we[0] = 1'b0;
      req[1] = 1'b1; addr[1] = 10'h020;
      for (int c = 0; c < 6; c++) begin
         addr[0] = AW'(mcount);
         step();
         check("t3_gnt", 64'(obs_gnt), (c == 4) ? 64'd2 : 64'd1);
         if (c == 4) check("t3_conflict", 64'(bus.conflict_cnt), 64'd5);
         if (last_win == 0) mcount++;
         if (last_win == 1) req[1] = 1'b0;
      end
      req[0] = 1'b0;
      step();

      // Three-way contention.
      reset_dut();
      g_tab = '{3'b001, 3'b010, 3'b100, 3'b000};
      r_tab = '{3'b000, 3'b001, 3'b010, 3'b100};
      for (int p = 0; p < 3; p++) begin
         req[p] = 1'b1; we[p] = 1'b0; addr[p] = AW'(10'h100 + p);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         check("t4_gnt", 64'(obs_gnt), 64'(g_tab[c]));
         check("t4_rvalid", 64'(obs_rv), 64'(r_tab[c]));
         if (last_win >= 0) req[last_win] = 1'b0;
      end

      // Halt gating.
      reset_dut();
      halted_v = 1'b1;
      req[1] = 1'b1; addr[1] = 10'h030;
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'h3FF; wdata[2] = 32'h1234_5678;
      for (int c = 0; c < 20; c++) begin
         step();
         check("t5_if_gnt", 64'(obs_gnt[1]), 64'd0);
         if (c == 0) check("t5_dbg_gnt", 64'(obs_gnt[2]), 64'd1);
         if (last_win == 2) req[2] = 1'b0;
      end
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = 10'h3FF;
      step();
      req[2] = 1'b0;
      drive();
      check("t5_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd1);
      check("t5_dbg_rdata", 64'(bus.rdata), 64'h1234_5678);
      halted_v = 1'b0;
      step();
      check("t5_if_after_halt", 64'(obs_gnt), 64'd2);
      req[1] = 1'b0;
      step();

      // Randomised traffic against the model.
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         refresh(60, 1'b0);
         step();
      end

      // Conflict counter saturation.
      reset_dut();
      for (int c = 0; c < (1 << CW) + 5; c++) begin
         refresh(100, 1'b1);
         step();
      end
      check("t7_conf_sat", 64'(bus.conflict_cnt), 64'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbiter and sequencer for the shared 1024 x 32 word memory of the MIPS32 pipeline.
- Serves three requesters over one single-port synchronous RAM: instruction fetch (IF), data access (MEM stage) and a debug/loader port (DBG).
- Issues at most one access per cycle with a 1-cycle read latency.
- Provides starvation protection, halt gating and a saturating conflict counter.

Parameters:
- AW, 10, word address width (memory depth 2^AW).
- DW, 32, data width.
- STARVE_LIMIT, 4, wait cycles after which a requester is promoted; legal range 1..15.
- CW, 16, conflict counter width.

Ports:
- clk1  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halted  in  1  pipeline halted; blocks IF grants.
- if_req  in  1  IF read request.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  rdata holds IF read data.
- mem_req  in  1  MEM-stage request.
- mem_we  in  1  MEM-stage write enable (1 = store).
- mem_addr  in  AW  MEM-stage word address.
- mem_wdata  in  DW  MEM-stage store data.
- mem_gnt  out  1  MEM-stage request accepted.
- mem_rvalid  out  1  rdata holds MEM-stage load data.
- dbg_req  in  1  debug/loader request.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  AW  debug word address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  debug request accepted.
- dbg_rvalid  out  1  rdata holds debug read data.
- rdata  out  DW  shared read-data return bus.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en & !ram_we.
- conflict_cnt  out  CW  saturating count of cycles with two or more eligible requests.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered state cleared: wait counters, read owner (none), conflict_cnt = 0.
  - All gnt/rvalid outputs = 0; ram_en = ram_we = 0; ram_addr = ram_wdata = 0; rdata = 0.
  - A read in flight at reset is dropped: no rvalid after deassertion.
- Eligibility: if_req & !halted; mem_req; dbg_req.
- Grant is combinational in the request cycle; exactly one or zero gnt per cycle.
- Requesters hold req, we, addr and wdata stable until gnt; after gnt they may change or drop next cycle.
- Priority:
  - Any requester whose wait counter == STARVE_LIMIT is starved and wins over all non-starved ones.
  - Among starved requesters, and when none is starved, the base order is MEM > IF > DBG.
- Wait counter (per port, 4 bits):
  - Increments each cycle the port is eligible and not granted; saturates at STARVE_LIMIT.
  - Clears on grant or whenever the port is not eligible.
  - IF counter is held at 0 while halted = 1.
- RAM drive: on grant, ram_en = 1 and ram_we/ram_addr/ram_wdata come from the winner in the same cycle; otherwise ram_en = 0, ram_we = 0.
- Read return:
  - A granted read registers its owner.
  - Next cycle, that port's rvalid = 1 and rdata = ram_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads from any mix of ports are fully pipelined, one per cycle.
- rdata is driven from ram_rdata only in rvalid cycles and holds 0 otherwise.
- halted = 1: if_gnt forced 0 even with if_req; MEM and DBG are unaffected.
- conflict_cnt: +1 each cycle with two or more eligible ports; saturates at 2^CW-1; no wrap.
- No read/write collision handling is needed: the single port makes same-cycle accesses impossible.

Test Plan:
- Reset and idle: assert rst_n = 0 mid-read (mem_req read, addr 0x005 granted, reset next edge) -> mem_rvalid never asserts; all outputs 0; conflict_cnt = 0.
- Single read latency: preload word 0x010 = 0xDEADBEEF; if_req, addr 0x010 in cycle 0 -> if_gnt = 1 in cycle 0; if_rvalid = 1 with rdata = 0xDEADBEEF in cycle 1.
- Priority plus starvation: mem_req held with addresses 0,1,2,... and if_req held from cycle 0, STARVE_LIMIT = 4 -> mem_gnt in cycles 0-3, if_gnt in cycle 4, mem_gnt again in cycle 5; conflict_cnt = 5 after cycle 4.
- Three-way contention: all three request in cycle 0 and stay until granted -> grant order MEM, IF, DBG over cycles 0, 1, 2; rvalid pulses in cycles 1, 2, 3 on the matching ports.
- Halt gating: halted = 1, if_req = 1 and dbg_req write 0x3FF = 0x12345678 -> dbg_gnt in cycle 0, if_gnt stays 0 for 20 cycles; a later dbg read of 0x3FF returns 0x12345678.
- Counter saturation: force 2 or more eligible requests for 2^CW + 5 cycles -> conflict_cnt = 0xFFFF, no wrap.
